lcd_line_counter: RTL and testbench

//  Dot/line timing generator for the DMG LCD. Produces LY (the v[7:0] bus read back at FF44) and
//  the STAT mode. Compares LY with LYC (FF45 latches) and raises the VBLANK and STAT interrupt

---
 rtl/dmg_video_pkg.sv | 39 +++
 rtl/lcd_stat_irq.sv | 55 +++++
 rtl/lcd_line_counter.sv | 184 ++++++++++++++++++
 tb/tb_lcd_line_counter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmg_video_pkg.sv
// -----------------------------------------------------------------------------
// dmg_video_pkg
// Shared definitions for the DMG LCD timing blocks:
//   lcd_mode_t   - STAT mode encoding (HBLANK/VBLANK/OAM/XFER)
//   timing constants used as defaults by lcd_line_counter
//   ly_readback  - LY value as seen on the FF44 read path (line-153 quirk)
// -----------------------------------------------------------------------------
package dmg_video_pkg;

  typedef enum logic [1:0] {
    HBLANK = 2'd0,
    VBLANK = 2'd1,
    OAM    = 2'd2,
    XFER   = 2'd3
  } lcd_mode_t;

  localparam int DOTS_PER_LINE = 32'd456;
  localparam int LINES         = 32'd154;
  localparam int VISIBLE_LINES = 32'd144;
  localparam int OAM_DOTS      = 32'd80;
  localparam int MODE3_MAX     = 32'd289;
  localparam int LY_LAST_EARLY = 32'd4;

  // On the last line of the frame the readback already shows 0 a few dots in,
  // while the internal line counter is still at its last value.
  function automatic logic [7:0] ly_readback(
    input logic [7:0] ly,
    input logic [8:0] h,
    input logic [7:0] ly_last,
    input logic [8:0] h_early
  );
    if ((ly == ly_last) && (h >= h_early)) begin
      return 8'd0;
    end else begin
      return ly;
    end
  endfunction

endpackage

// File: rtl/lcd_stat_irq.sv
// -----------------------------------------------------------------------------
// lcd_stat_irq
// Builds the STAT interrupt line from the enabled sources and turns its rising
// edge into a one-cycle request. A source handing over to another enabled
// source with no low gap in between produces no new request.
// Ports:
//   clk        in  1  dot clock
//   reset      in  1  synchronous, active-high
//   clear      in  1  display off: drop the request and forget the line history
//   stat_ie    in  4  {lyc_ie, m2_ie, m1_ie, m0_ie}
//   mode       in  2  mode the counter will show next cycle
//   lyc_match  in  1  LY==LYC flag the counter will show next cycle
//   int_stat   out 1  one-cycle STAT request (registered)
// -----------------------------------------------------------------------------
module lcd_stat_irq
  import dmg_video_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [3:0] stat_ie,
  input  logic [1:0] mode,
  input  logic       lyc_match,
  output logic       int_stat
);

  logic line_s;
  logic line_r;
  logic int_stat_r;

  // OR of all enabled STAT sources for the upcoming cycle
  always_comb begin
    line_s = (stat_ie[3] & lyc_match)
           | (stat_ie[2] & (mode == OAM))
           | (stat_ie[1] & (mode == VBLANK))
           | (stat_ie[0] & (mode == HBLANK));
  end

  // Line history and rising-edge request register
  always_ff @(posedge clk) begin
    if (reset) begin
      line_r     <= 1'b0;
      int_stat_r <= 1'b0;
    end else if (clear) begin
      line_r     <= 1'b0;
      int_stat_r <= 1'b0;
    end else begin
      line_r     <= line_s;
      int_stat_r <= line_s & ~line_r;
    end
  end

  assign int_stat = int_stat_r;

endmodule

// File: rtl/lcd_line_counter.sv
// -----------------------------------------------------------------------------
// lcd_line_counter
// Dot/line timing generator for the DMG LCD: dot counter h, line counter ly,
// STAT mode sequencing, LY/LYC compare and the VBLANK / STAT interrupt
// requests. Every output is a register.
// Ports:
//   clk         in  1  dot clock
//   reset       in  1  synchronous, active-high
//   lcd_on      in  1  LCDC bit 7; low holds everything in the idle state
//   lyc         in  8  LYC register
//   stat_ie     in  4  {lyc_ie, m2_ie, m1_ie, m0_ie}
//   mode3_done  in  1  pixel pipeline finished the line (1-cycle pulse)
//   v           out 8  LY as read back at FF44
//   h           out 9  dot within the line
//   mode        out 2  STAT mode
//   line_start  out 1  pulse on h==0
//   lyc_match   out 1  registered v==lyc
//   int_vblank  out 1  VBLANK request pulse
//   int_stat    out 1  STAT request pulse
// -----------------------------------------------------------------------------
module lcd_line_counter #(
  parameter int DOTS_PER_LINE = dmg_video_pkg::DOTS_PER_LINE,
  parameter int LINES         = dmg_video_pkg::LINES,
  parameter int VISIBLE_LINES = dmg_video_pkg::VISIBLE_LINES,
  parameter int OAM_DOTS      = dmg_video_pkg::OAM_DOTS,
  parameter int MODE3_MAX     = dmg_video_pkg::MODE3_MAX,
  parameter int LY_LAST_EARLY = dmg_video_pkg::LY_LAST_EARLY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_on,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_ie,
  input  logic       mode3_done,
  output logic [7:0] v,
  output logic [8:0] h,
  output logic [1:0] mode,
  output logic       line_start,
  output logic       lyc_match,
  output logic       int_vblank,
  output logic       int_stat
);
  import dmg_video_pkg::*;

  localparam logic [8:0] H_LAST       = 9'(DOTS_PER_LINE - 32'd1);
  localparam logic [8:0] H_XFER_START = 9'(OAM_DOTS);
  localparam logic [8:0] H_XFER_LAST  = 9'(OAM_DOTS + MODE3_MAX - 32'd1);
  localparam logic [8:0] H_LY_EARLY   = 9'(LY_LAST_EARLY);
  localparam logic [7:0] LY_LAST      = 8'(LINES - 32'd1);
  localparam logic [7:0] LY_VBLANK    = 8'(VISIBLE_LINES);

  logic       hold_s;
  logic       running_r;
  logic       running_s;
  logic [8:0] h_r;
  logic [8:0] h_s;
  logic [7:0] ly_r;
  logic [7:0] ly_s;
  lcd_mode_t  mode_r;
  lcd_mode_t  mode_s;
  logic [7:0] v_r;
  logic [7:0] v_s;
  logic       line_start_r;
  logic       line_start_s;
  logic       lyc_match_r;
  logic       lyc_match_s;
  logic       int_vblank_r;
  logic       int_vblank_s;

  assign hold_s = reset | ~lcd_on;

  // Dot and line counters. Leaving the idle state starts at h=0 rather than
  // advancing, so the first active cycle is dot 0 of line 0.
  always_comb begin
    running_s = 1'b0;
    h_s       = 9'd0;
    ly_s      = 8'd0;
    if (hold_s) begin
      running_s = 1'b0;
    end else if (!running_r) begin
      running_s = 1'b1;
    end else begin
      running_s = 1'b1;
      if (h_r == H_LAST) begin
        h_s  = 9'd0;
        ly_s = (ly_r == LY_LAST) ? 8'd0 : (ly_r + 8'd1);
      end else begin
        h_s  = h_r + 9'd1;
        ly_s = ly_r;
      end
    end
  end

  // Mode FSM next state. XFER ends one cycle after mode3_done, or after its
  // last allowed dot; mode3_done is only acted on while in XFER.
  always_comb begin
    mode_s = mode_r;
    if (!running_s) begin
      mode_s = HBLANK;
    end else if (ly_s >= LY_VBLANK) begin
      mode_s = VBLANK;
    end else if (h_s < H_XFER_START) begin
      mode_s = OAM;
    end else begin
      case (mode_r)
        OAM: begin
          mode_s = XFER;
        end
        XFER: begin
          if (mode3_done || (h_r == H_XFER_LAST)) begin
            mode_s = HBLANK;
          end else begin
            mode_s = XFER;
          end
        end
        HBLANK: begin
          mode_s = HBLANK;
        end
        default: begin
          mode_s = HBLANK;
        end
      endcase
    end
  end

  // Next values of the remaining outputs. lyc_match compares the v that is
  // currently visible, which gives the one-cycle latency after a v or lyc change.
  always_comb begin
    v_s          = ly_readback(ly_s, h_s, LY_LAST, H_LY_EARLY);
    line_start_s = running_s & (h_s == 9'd0);
    lyc_match_s  = running_s & (v_r == lyc);
    int_vblank_s = running_s & (ly_s == LY_VBLANK) & (h_s == 9'd0);
  end

  // Mode state register
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r <= HBLANK;
    end else begin
      mode_r <= mode_s;
    end
  end

  // Counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      running_r    <= 1'b0;
      h_r          <= 9'd0;
      ly_r         <= 8'd0;
      v_r          <= 8'd0;
      line_start_r <= 1'b0;
      lyc_match_r  <= 1'b0;
      int_vblank_r <= 1'b0;
    end else begin
      running_r    <= running_s;
      h_r          <= h_s;
      ly_r         <= ly_s;
      v_r          <= v_s;
      line_start_r <= line_start_s;
      lyc_match_r  <= lyc_match_s;
      int_vblank_r <= int_vblank_s;
    end
  end

  // The STAT edge detector looks at next-cycle mode/match so its request lines
  // up with the mode and lyc_match outputs that caused it.
  lcd_stat_irq u_stat_irq (
    .clk       (clk),
    .reset     (reset),
    .clear     (~running_s),
    .stat_ie   (stat_ie),
    .mode      (mode_s),
    .lyc_match (lyc_match_s),
    .int_stat  (int_stat)
  );

  assign v          = v_r;
  assign h          = h_r;
  assign mode       = mode_r;
  assign line_start = line_start_r;
  assign lyc_match  = lyc_match_r;
  assign int_vblank = int_vblank_r;

endmodule

// File: tb/tb_lcd_line_counter.sv
// -----------------------------------------------------------------------------
// tb_lcd_line_counter
// Self-checking bench for lcd_line_counter. A behavioural model tracks the
// frame position as a single dot count and derives h/ly/mode/interrupts from
// it with plain arithmetic; every DUT output is compared each cycle, and
// extra directed checks sit at the interesting frame positions.
// -----------------------------------------------------------------------------
module tb_lcd_line_counter;

  localparam int DOTS   = 456;
  localparam int NLINES = 154;
  localparam int FRAME  = DOTS * NLINES;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_on;
  logic [7:0] lyc;
  logic [3:0] stat_ie;
  logic       mode3_done;
  logic [7:0] v;
  logic [8:0] h;
  logic [1:0] mode;
  logic       line_start;
  logic       lyc_match;
  logic       int_vblank;
  logic       int_stat;

  int n_vec = 0;
  int n_err = 0;
  int ls_cnt = 0;

  // model state
  bit m_on = 1'b0;
  int m_t = 0;
  int m_h = 0;
  int m_ly = 0;
  int m_v = 0;
  int m_mode = 0;
  int m_end = 369;
  bit m_ls = 1'b0;
  bit m_match = 1'b0;
  bit m_vb = 1'b0;
  bit m_st = 1'b0;
  bit m_line = 1'b0;

  lcd_line_counter dut (
    .clk        (clk),
    .reset      (reset),
    .lcd_on     (lcd_on),
    .lyc        (lyc),
    .stat_ie    (stat_ie),
    .mode3_done (mode3_done),
    .v          (v),
    .h          (h),
    .mode       (mode),
    .line_start (line_start),
    .lyc_match  (lyc_match),
    .int_vblank (int_vblank),
    .int_stat   (int_stat)
  );

  always #5 clk = ~clk;

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at ly=%0d h=%0d: observed=%0d expected=%0d", tag, m_ly, m_h, obs, exp);
    end
  endtask

  // Reference model: one step per clock, from the inputs present at the edge.
  task automatic model_update();
    int  v_old;
    int  mode_old;
    int  h_old;
    bit  line;
    v_old    = m_v;
    mode_old = m_mode;
    h_old    = m_h;
    if (reset || !lcd_on) begin
      m_on = 1'b0; m_t = 0; m_h = 0; m_ly = 0; m_v = 0; m_mode = 0; m_end = 369;
      m_ls = 1'b0; m_match = 1'b0; m_vb = 1'b0; m_st = 1'b0; m_line = 1'b0;
    end else begin
      if (m_on && mode_old == 3 && mode3_done) m_end = h_old + 1;
      m_match = (v_old == int'(lyc));
      if (!m_on) m_t = 0;
      else m_t = (m_t + 1) % FRAME;
      m_on = 1'b1;
      m_h  = m_t % DOTS;
      m_ly = m_t / DOTS;
      if (m_h == 0) m_end = 369;
      m_v = (m_ly == 153 && m_h >= 4) ? 0 : m_ly;
      if (m_ly >= 144) m_mode = 1;
      else if (m_h < 80) m_mode = 2;
      else if (m_h < m_end) m_mode = 3;
      else m_mode = 0;
      m_ls = (m_h == 0);
      m_vb = (m_ly == 144 && m_h == 0);
      line = (stat_ie[3] && m_match) || (stat_ie[2] && m_mode == 2) ||
             (stat_ie[1] && m_mode == 1) || (stat_ie[0] && m_mode == 0);
      m_st   = line && !m_line;
      m_line = line;
    end
  endtask

  // Fixed expectations at notable frame positions.
  task automatic point_checks();
    if (!m_on) return;
    if (m_ly == 0 && m_h == 79)  check("l0_oam_last", 16'(mode), 16'd2);
    if (m_ly == 0 && m_h == 80)  check("l0_xfer_first", 16'(mode), 16'd3);
    if (m_ly == 0 && m_h == 368) check("l0_xfer_timeout_last", 16'(mode), 16'd3);
    if (m_ly == 0 && m_h == 369) check("l0_hblank_first", 16'(mode), 16'd0);
    if (m_ly == 1 && m_h == 0) begin
      check("wrap_h", 16'(h), 16'd0);
      check("wrap_v", 16'(v), 16'd1);
      check("m0_to_m2_blocked", 16'(int_stat), 16'd0);
    end
    if (m_ly == 1 && m_h == 251) check("m3done_cycle", 16'(mode), 16'd3);
    if (m_ly == 1 && m_h == 252) check("m3done_next", 16'(mode), 16'd0);
    if (m_ly == 153 && m_h == 3) check("l153_v_h3", 16'(v), 16'd153);
    if (m_ly == 153 && m_h == 4) check("l153_v_h4", 16'(v), 16'd0);
    if (m_ly == 153 && m_h == 5) begin
      check("l153_lyc_match", 16'(lyc_match), 16'd1);
      check("l153_int_stat", 16'(int_stat), 16'd1);
    end
    if (m_ly == 144 && m_h == 0) begin
      check("vblank_pulse", 16'(int_vblank), 16'd1);
      check("vblank_stat", 16'(int_stat), 16'd1);
      check("vblank_mode", 16'(mode), 16'd1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("h", 16'(h), 16'(m_h));
    check("v", 16'(v), 16'(m_v));
    check("mode", 16'(mode), 16'(m_mode));
    check("line_start", 16'(line_start), 16'(m_ls));
    check("lyc_match", 16'(lyc_match), 16'(m_match));
    check("int_vblank", 16'(int_vblank), 16'(m_vb));
    check("int_stat", 16'(int_stat), 16'(m_st));
    point_checks();
    if (n_err >= 40) finish_run();
  endtask

  // Per-cycle stimulus chosen from the position of the cycle in progress.
  task automatic drive();
    mode3_done = ((m_ly == 1 && m_h == 251) ||
                  (m_ly >= 2 && $urandom_range(0, 149) == 0)) ? 1'b1 : 1'b0;
    if (m_h == 0) begin
      if (m_ly <= 1) stat_ie = 4'b1111;
      else if (m_ly >= 140 && m_ly <= 144) stat_ie = 4'b0010;
      else if (m_ly >= 150) stat_ie = 4'b1000;
      else stat_ie = 4'($urandom);
      if (m_ly >= 150) lyc = 8'd0;
      else begin
        case ($urandom_range(0, 2))
          0:       lyc = 8'(m_ly);
          1:       lyc = 8'(m_ly + 1);
          default: lyc = 8'($urandom);
        endcase
      end
    end else if (m_h == 200 && m_ly < 150 && $urandom_range(0, 3) == 0) begin
      lyc = 8'(m_ly);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_h"}, 16'(h), 16'd0);
    check({tag, "_v"}, 16'(v), 16'd0);
    check({tag, "_mode"}, 16'(mode), 16'd0);
    check({tag, "_line_start"}, 16'(line_start), 16'd0);
    check({tag, "_lyc_match"}, 16'(lyc_match), 16'd0);
    check({tag, "_int_vblank"}, 16'(int_vblank), 16'd0);
    check({tag, "_int_stat"}, 16'(int_stat), 16'd0);
  endtask

  initial begin
    reset      = 1'b1;
    lcd_on     = 1'b1;
    lyc        = 8'd7;
    stat_ie    = 4'b1111;
    mode3_done = 1'b0;

    // reset held for three cycles
    for (int i = 0; i < 3; i++) step();
    check_all_zero("reset");

    // one complete frame from the first active cycle
    reset = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      drive();
      step();
      if (line_start) ls_cnt++;
    end
    check("line_starts_per_frame", 16'(ls_cnt), 16'd154);
    drive();
    step();
    check("frame_wrap_h", 16'(h), 16'd0);
    check("frame_wrap_v", 16'(v), 16'd0);
    check("frame_wrap_line_start", 16'(line_start), 16'd1);

    // run to ly=50, h=200 and drop lcd_on
    for (int i = 0; i < 30000 && !(m_ly == 50 && m_h == 200); i++) begin
      drive();
      step();
    end
    check("drop_point_v", 16'(v), 16'd50);
    check("drop_point_h", 16'(h), 16'd200);
    mode3_done = 1'b0;
    lcd_on     = 1'b0;
    step();
    check_all_zero("lcd_off");
    for (int i = 0; i < 3; i++) step();
    check_all_zero("lcd_off_hold");

    // re-enable: first active cycle
    stat_ie = 4'b0001;
    lyc     = 8'd9;
    lcd_on  = 1'b1;
    step();
    check("reon_h", 16'(h), 16'd0);
    check("reon_v", 16'(v), 16'd0);
    check("reon_mode", 16'(mode), 16'd2);
    check("reon_line_start", 16'(line_start), 16'd1);
    check("reon_int_vblank", 16'(int_vblank), 16'd0);
    check("reon_int_stat", 16'(int_stat), 16'd0);

    // synchronous reset mid-line with the display on
    for (int i = 0; i < 2000 && !(m_ly == 1 && m_h == 300); i++) begin
      drive();
      step();
    end
    check("reset_point_v", 16'(v), 16'd1);
    check("reset_point_h", 16'(h), 16'd300);
    mode3_done = 1'b0;
    reset      = 1'b1;
    step();
    check("midreset_h", 16'(h), 16'd0);
    check("midreset_v", 16'(v), 16'd0);
    check("midreset_mode", 16'(mode), 16'd0);
    check("midreset_lyc_match", 16'(lyc_match), 16'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive();
      step();
    end

    finish_run();
  end

endmodule
